// File: rtl/lsmitll_dfft_deserializer.sv
// Capture stage for an edge-encoded DFFT output: turns dq/dclk toggles into
// parallel MSB-first words on a valid/ready port and flags pulse-rule errors.
module lsmitll_dfft_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_dq,
  input  logic             i_dclk,
  input  logic             i_err_clr,
  output logic [WIDTH-1:0] o_word,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic [2:0]       o_err
);

  // state | meaning
  // ARM   | first cycle after reset, prime edge detectors, no events
  // EMPTY | window open, no data pulse held
  // HELD  | window open, data pulse held (next clock shifts a 1)
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_ARM   = 2'd0;
  localparam logic [1:0] S_EMPTY = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;

  logic [1:0]       r_state;
  logic             r_dq_s, r_dq_prev, r_dclk_s, r_dclk_prev;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_cmp_vld;
  logic [WIDTH-1:0] r_word;
  logic             r_word_valid;
  logic [2:0]       r_err;

  logic       w_armed, w_d_ev, w_c_ev, w_held, w_bit, w_last, w_accept, w_ovf;
  logic [2:0] w_err_set;
  logic [1:0] w_state_nxt;

  assign w_armed   = (r_state != S_ARM);
  assign w_d_ev    = w_armed & (r_dq_s ^ r_dq_prev);
  assign w_c_ev    = w_armed & (r_dclk_s ^ r_dclk_prev);
  assign w_held    = (r_state == S_HELD);
  assign w_bit     = w_held | w_d_ev;
  assign w_last    = (r_bit_cnt == CW'(WIDTH - 1));
  assign w_accept  = r_word_valid & i_word_ready;
  assign w_ovf     = r_cmp_vld & r_word_valid & ~i_word_ready;
  assign w_err_set = {w_ovf, w_d_ev & w_c_ev, w_d_ev & w_held};

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_ARM)  w_state_nxt = S_EMPTY;
    else if (w_c_ev)       w_state_nxt = S_EMPTY;
    else if (w_d_ev)       w_state_nxt = S_HELD;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_ARM;
      r_dq_s       <= 1'b0;
      r_dq_prev    <= 1'b0;
      r_dclk_s     <= 1'b0;
      r_dclk_prev  <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_cmp_vld    <= 1'b0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_err        <= 3'b000;
    end else begin
      // In ARM both stages load the live level so release levels never look like pulses
      if (r_state == S_ARM) begin
        r_dq_s      <= i_dq;
        r_dq_prev   <= i_dq;
        r_dclk_s    <= i_dclk;
        r_dclk_prev <= i_dclk;
      end else begin
        r_dq_s      <= i_dq;
        r_dq_prev   <= r_dq_s;
        r_dclk_s    <= i_dclk;
        r_dclk_prev <= r_dclk_s;
      end

      r_state <= w_state_nxt;

      if (w_c_ev) begin
        r_shift   <= {r_shift[WIDTH-2:0], w_bit};
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + CW'(1);
      end
      r_cmp_vld <= w_c_ev & w_last;

      // Completed word sits in r_shift for one cycle; load it before the next shift lands
      if (r_cmp_vld && (!r_word_valid || i_word_ready)) begin
        r_word       <= r_shift;
        r_word_valid <= 1'b1;
      end else if (w_accept) begin
        r_word_valid <= 1'b0;
      end

      r_err <= (i_err_clr ? 3'b000 : r_err) | w_err_set;
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_err        = r_err;

endmodule
